// File: rtl/cpsr_banked_unit_if.sv
// Status-unit bus: ALU results and exception control from the core, and the
// condition, status and handshake outputs back to it.
interface cpsr_banked_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int MODE_WIDTH = 2
);
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_carry;
  logic                  alu_overflow;
  logic                  set_cond_bit;
  logic [3:0]            cond_field;
  logic                  exc_req;
  logic [MODE_WIDTH-1:0] exc_mode;
  logic                  exc_return;
  logic                  write_condition;
  logic [3:0]            current_flags;
  logic [31:0]           cpsr_out;
  logic [31:0]           spsr_out;
  logic                  busy;
  logic                  exc_ack;
  logic                  status_error;

  modport master (
    output alu_result, alu_carry, alu_overflow, set_cond_bit, cond_field,
           exc_req, exc_mode, exc_return,
    input  write_condition, current_flags, cpsr_out, spsr_out, busy,
           exc_ack, status_error
  );

  modport slave (
    input  alu_result, alu_carry, alu_overflow, set_cond_bit, cond_field,
           exc_req, exc_mode, exc_return,
    output write_condition, current_flags, cpsr_out, spsr_out, busy,
           exc_ack, status_error
  );
endinterface

// File: rtl/cpsr_banked_unit.sv
// Status register with NZCV/I/mode, condition evaluation, per-mode banked SPSRs,
// a two-cycle exception-entry sequencer and single-cycle exception return.
module cpsr_banked_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_MODES  = 4,
  parameter int MODE_WIDTH = 2,
  parameter int RESET_MODE = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  cpsr_banked_unit_if.slave     bus
);

  localparam int MODE_CNT = 2 ** MODE_WIDTH;
  localparam logic [MODE_WIDTH-1:0] RST_MODE = MODE_WIDTH'(RESET_MODE);

  // Bit m set when lo <= m < NUM_MODES; avoids range compares against constants.
  function automatic logic [MODE_CNT-1:0] mode_mask(input int lo);
    logic [MODE_CNT-1:0] m;
    m = '0;
    for (int i = 0; i < MODE_CNT; i++) m[i] = (i >= lo) && (i < NUM_MODES);
    return m;
  endfunction

  localparam logic [MODE_CNT-1:0] BANKED = mode_mask(1);
  localparam logic [MODE_CNT-1:0] LEGAL  = mode_mask(0);

  function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'b0000: return z;
      4'b0001: return !z;
      4'b0010: return c;
      4'b0011: return !c;
      4'b0100: return n;
      4'b0101: return !n;
      4'b0110: return v;
      4'b0111: return !v;
      4'b1000: return c && !z;
      4'b1001: return !c || z;
      4'b1010: return n == v;
      4'b1011: return n != v;
      4'b1100: return !z && (n == v);
      4'b1101: return z || (n != v);
      4'b1110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] cpsr_word(input logic [3:0] f, input logic i,
                                            input logic [MODE_WIDTH-1:0] m);
    logic [31:0] w;
    w = '0;
    w[31:28] = f;
    w[7] = i;
    w[MODE_WIDTH-1:0] = m;
    return w;
  endfunction

  typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_SWITCH} state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_flags;
  logic                  r_ibit;
  logic [MODE_WIDTH-1:0] r_mode;
  logic [MODE_WIDTH-1:0] r_tgt;
  logic                  r_err;
  logic [31:0]           r_spsr [MODE_CNT];

  logic [3:0]  w_new_flags;
  logic        w_cond;
  logic [31:0] w_cpsr;
  logic        w_entry_go, w_flag_we, w_ret_go, w_err;

  assign w_new_flags = {bus.alu_result[DATA_WIDTH-1], bus.alu_result == '0,
                        bus.alu_carry, bus.alu_overflow};
  assign w_cond      = cond_pass(bus.cond_field, r_flags);
  assign w_cpsr      = cpsr_word(r_flags, r_ibit, r_mode);

  // Priority in IDLE: entry over return, return over flag write.
  always_comb begin
    w_state_nxt = r_state;
    w_entry_go  = 1'b0;
    w_flag_we   = 1'b0;
    w_ret_go    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.exc_req) begin
          if (BANKED[bus.exc_mode]) begin
            w_entry_go  = 1'b1;
            w_state_nxt = ST_SAVE;
          end else begin
            w_err = 1'b1;
          end
          w_flag_we = bus.set_cond_bit && w_cond;
        end else if (bus.exc_return) begin
          if (BANKED[r_mode]) begin
            w_ret_go = 1'b1;
            w_err    = !LEGAL[r_spsr[r_mode][MODE_WIDTH-1:0]];
          end else begin
            w_err = 1'b1;
          end
        end else begin
          w_flag_we = bus.set_cond_bit && w_cond;
        end
      end
      ST_SAVE:   w_state_nxt = ST_SWITCH;
      ST_SWITCH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_flags <= '0;
      r_ibit  <= 1'b1;
      r_mode  <= RST_MODE;
      r_tgt   <= '0;
      r_err   <= 1'b0;
      for (int k = 0; k < MODE_CNT; k++) r_spsr[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err;
      if (w_entry_go) r_tgt <= bus.exc_mode;
      if (w_flag_we) r_flags <= w_new_flags;
      if (w_ret_go) begin
        r_flags <= r_spsr[r_mode][31:28];
        r_ibit  <= r_spsr[r_mode][7];
        r_mode  <= r_spsr[r_mode][MODE_WIDTH-1:0];
      end
      if (r_state == ST_SAVE) r_spsr[r_tgt] <= w_cpsr;
      if (r_state == ST_SWITCH) begin
        r_mode <= r_tgt;
        r_ibit <= 1'b1;
      end
    end
  end

  // User mode and unbanked indices are never written, so they always read zero.
  assign bus.write_condition = w_cond;
  assign bus.current_flags   = r_flags;
  assign bus.cpsr_out        = w_cpsr;
  assign bus.spsr_out        = r_spsr[r_mode];
  assign bus.busy            = (r_state != ST_IDLE);
  assign bus.exc_ack         = (r_state == ST_SWITCH);
  assign bus.status_error    = r_err;

endmodule

// File: tb/tb_cpsr_banked_unit.sv
// Directed bench for cpsr_banked_unit: flags, condition codes, entry/return,
// error pulses and reset during the entry sequence; second instance resets to mode 0.
module tb_cpsr_banked_unit;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  cpsr_banked_unit_if #(.DATA_WIDTH(32), .MODE_WIDTH(2)) bus  ();
  cpsr_banked_unit_if #(.DATA_WIDTH(32), .MODE_WIDTH(2)) bus0 ();

  cpsr_banked_unit #(.DATA_WIDTH(32), .NUM_MODES(4), .MODE_WIDTH(2), .RESET_MODE(1))
    u_dut (.clock(clk), .reset(rst), .bus(bus));

  cpsr_banked_unit #(.DATA_WIDTH(32), .NUM_MODES(4), .MODE_WIDTH(2), .RESET_MODE(0))
    u_dut0 (.clock(clk), .reset(rst), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.alu_result = '0;  bus.alu_carry = 0;  bus.alu_overflow = 0;
    bus.set_cond_bit = 0; bus.cond_field = 4'h0; bus.exc_req = 0;
    bus.exc_mode = 2'd0;  bus.exc_return = 0;
    bus0.alu_result = '0; bus0.alu_carry = 0; bus0.alu_overflow = 0;
    bus0.set_cond_bit = 0; bus0.cond_field = 4'h0; bus0.exc_req = 0;
    bus0.exc_mode = 2'd0; bus0.exc_return = 0;
    repeat (2) tick();
    rst = 1'b0;
    #1;

    chk("rst_cpsr",  bus.cpsr_out, 32'h0000_0081);
    chk("rst_spsr",  bus.spsr_out, 32'h0);
    chk("rst_busy",  32'(bus.busy), 32'h0);
    chk("rst_ack",   32'(bus.exc_ack), 32'h0);
    chk("rst_err",   32'(bus.status_error), 32'h0);
    chk("rst_flags", 32'(bus.current_flags), 32'h0);
    bus.cond_field = 4'b0000; #1; chk("cond_eq_rst", 32'(bus.write_condition), 32'h0);
    bus.cond_field = 4'b1110; #1; chk("cond_al",     32'(bus.write_condition), 32'h1);
    bus.cond_field = 4'b1111; #1; chk("cond_nv",     32'(bus.write_condition), 32'h0);

    // Z and C from a zero result with carry
    bus.alu_result = 32'h0; bus.alu_carry = 1; bus.alu_overflow = 0;
    bus.set_cond_bit = 1; bus.cond_field = 4'b1110;
    tick();
    bus.set_cond_bit = 0;
    chk("flags_zc", 32'(bus.current_flags), 32'h6);
    bus.cond_field = 4'b1000; #1; chk("cond_hi", 32'(bus.write_condition), 32'h0);
    bus.cond_field = 4'b1001; #1; chk("cond_ls", 32'(bus.write_condition), 32'h1);

    // N and V, written under EQ which passes while Z=1
    bus.alu_result = 32'h8000_0000; bus.alu_carry = 0; bus.alu_overflow = 1;
    bus.set_cond_bit = 1; bus.cond_field = 4'b0000;
    tick();
    bus.set_cond_bit = 0;
    chk("flags_nv", 32'(bus.current_flags), 32'h9);
    bus.cond_field = 4'b1010; #1; chk("cond_ge", 32'(bus.write_condition), 32'h1);
    bus.cond_field = 4'b1011; #1; chk("cond_lt", 32'(bus.write_condition), 32'h0);
    bus.cond_field = 4'b1101; #1; chk("cond_le", 32'(bus.write_condition), 32'h0);

    // EQ fails now, so this write must be dropped
    bus.alu_result = 32'h0; bus.alu_carry = 1; bus.alu_overflow = 0;
    bus.set_cond_bit = 1; bus.cond_field = 4'b0000;
    tick();
    bus.set_cond_bit = 0;
    chk("flags_blocked", 32'(bus.current_flags), 32'h9);

    bus.alu_result = 32'h8000_0000; bus.alu_carry = 0; bus.alu_overflow = 0;
    bus.set_cond_bit = 1; bus.cond_field = 4'b1110;
    tick();
    chk("flags_n", 32'(bus.current_flags), 32'h8);

    // Entry to mode 2 with a same-cycle flag write of 0100
    bus.alu_result = 32'h0; bus.exc_req = 1; bus.exc_mode = 2'd2;
    tick();
    chk("save_busy",  32'(bus.busy), 32'h1);
    chk("save_ack",   32'(bus.exc_ack), 32'h0);
    chk("save_flags", 32'(bus.current_flags), 32'h4);
    chk("save_cpsr",  bus.cpsr_out, 32'h4000_0081);
    bus.alu_result = 32'h8000_0000;
    tick();
    bus.set_cond_bit = 0;
    chk("sw_busy",  32'(bus.busy), 32'h1);
    chk("sw_ack",   32'(bus.exc_ack), 32'h1);
    chk("sw_flags", 32'(bus.current_flags), 32'h4);
    chk("sw_cpsr",  bus.cpsr_out, 32'h4000_0081);
    bus.exc_req = 0;
    tick();
    chk("ent_busy", 32'(bus.busy), 32'h0);
    chk("ent_ack",  32'(bus.exc_ack), 32'h0);
    chk("ent_cpsr", bus.cpsr_out, 32'h4000_0082);
    chk("ent_spsr", bus.spsr_out, 32'h4000_0081);

    // Return wins over a flag write that would give 0110
    bus.exc_return = 1; bus.set_cond_bit = 1;
    bus.alu_result = 32'h0; bus.alu_carry = 1; bus.cond_field = 4'b1110;
    tick();
    bus.exc_return = 0; bus.set_cond_bit = 0;
    chk("ret_cpsr", bus.cpsr_out, 32'h4000_0081);
    chk("ret_err",  32'(bus.status_error), 32'h0);
    chk("ret_spsr", bus.spsr_out, 32'h0);

    bus.exc_req = 1; bus.exc_mode = 2'd0;
    tick();
    bus.exc_req = 0;
    chk("bad_mode_err",  32'(bus.status_error), 32'h1);
    chk("bad_mode_busy", 32'(bus.busy), 32'h0);
    chk("bad_mode_cpsr", bus.cpsr_out, 32'h4000_0081);
    tick();
    chk("err_pulse_end", 32'(bus.status_error), 32'h0);

    // Re-entry into mode 1 overwrites SPSR[1]
    bus.exc_req = 1; bus.exc_mode = 2'd1;
    tick();
    tick();
    chk("reent_ack", 32'(bus.exc_ack), 32'h1);
    bus.exc_req = 0;
    tick();
    chk("reent_cpsr", bus.cpsr_out, 32'h4000_0081);
    chk("reent_spsr", bus.spsr_out, 32'h4000_0081);

    // Reset asserted during SAVE of another mode-1 entry
    bus.exc_req = 1; bus.exc_mode = 2'd1;
    tick();
    chk("mid_busy", 32'(bus.busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cpsr",  bus.cpsr_out, 32'h0000_0081);
    chk("mid_rst_busy",  32'(bus.busy), 32'h0);
    chk("mid_rst_spsr",  bus.spsr_out, 32'h0);
    chk("mid_rst_flags", 32'(bus.current_flags), 32'h0);
    bus.exc_req = 0;
    tick();
    chk("mid_rst_ack1", 32'(bus.exc_ack), 32'h0);
    rst = 1'b0;
    tick();
    chk("mid_rst_ack2", 32'(bus.exc_ack), 32'h0);
    chk("mid_rst_busy2", 32'(bus.busy), 32'h0);
    chk("mid_rst_spsr2", bus.spsr_out, 32'h0);
    chk("mid_rst_cpsr2", bus.cpsr_out, 32'h0000_0081);

    // Instance reset into user mode
    chk("u_rst_cpsr", bus0.cpsr_out, 32'h0000_0080);
    chk("u_rst_spsr", bus0.spsr_out, 32'h0);
    bus0.exc_return = 1;
    tick();
    bus0.exc_return = 0;
    chk("u_ret_err",  32'(bus0.status_error), 32'h1);
    chk("u_ret_cpsr", bus0.cpsr_out, 32'h0000_0080);
    tick();
    bus0.exc_req = 1; bus0.exc_mode = 2'd3;
    bus0.set_cond_bit = 1; bus0.alu_result = 32'h0; bus0.alu_carry = 1;
    bus0.cond_field = 4'b1110;
    tick();
    bus0.set_cond_bit = 0;
    tick();
    bus0.exc_req = 0;
    tick();
    chk("u_ent_cpsr", bus0.cpsr_out, 32'h6000_0083);
    chk("u_ent_spsr", bus0.spsr_out, 32'h6000_0080);
    bus0.exc_return = 1;
    tick();
    bus0.exc_return = 0;
    chk("u_back_cpsr", bus0.cpsr_out, 32'h6000_0080);
    chk("u_back_err",  32'(bus0.status_error), 32'h0);
    bus0.exc_return = 1;
    tick();
    bus0.exc_return = 0;
    chk("u_ret2_err",  32'(bus0.status_error), 32'h1);
    chk("u_ret2_cpsr", bus0.cpsr_out, 32'h6000_0080);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpsr_banked_unit.md
Name: cpsr_banked_unit

Overview:
- Parametrised successor to the current condition/flag block.
- Holds a full status register: NZCV flags, IRQ-disable bit I, and a mode field.
- Evaluates all 16 ARM condition codes and generates NZCV from ALU outputs, including carry and overflow.
- Keeps one banked saved-status register (SPSR) per privileged mode, with a multi-cycle exception-entry sequencer and a single-cycle exception return. Sits between the ALU and the control unit.

Parameters:
DATA_WIDTH, 32, width of alu_result; N = alu_result[DATA_WIDTH-1].
NUM_MODES, 4, number of modes; mode 0 = user (no SPSR), modes 1..NUM_MODES-1 banked.
MODE_WIDTH, 2, width of mode field; must satisfy 2^MODE_WIDTH >= NUM_MODES.
RESET_MODE, 1, mode loaded at reset.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
alu_result  in  DATA_WIDTH  ALU result, used for N and Z.
alu_carry  in  1  ALU carry-out, becomes C.
alu_overflow  in  1  ALU signed overflow, becomes V.
set_cond_bit  in  1  instruction S bit: request flag update.
cond_field  in  4  condition code of the current instruction.
exc_req  in  1  exception-entry request; held until exc_ack.
exc_mode  in  MODE_WIDTH  target mode for entry; sampled when the request is accepted.
exc_return  in  1  one-cycle pulse: restore CPSR from the current mode's SPSR.
write_condition  out  1  condition passed on current flags (combinational).
current_flags  out  4  {N,Z,C,V} currently registered.
cpsr_out  out  32  [31:28]=NZCV, [7]=I, [MODE_WIDTH-1:0]=mode, all other bits 0.
spsr_out  out  32  SPSR of current mode; 0 when in mode 0.
busy  out  1  high while the entry sequencer is not IDLE.
exc_ack  out  1  one-cycle pulse when the new mode is in effect.
status_error  out  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset (async, any state): NZCV=0, I=1, mode=RESET_MODE, all SPSRs=0, FSM=IDLE, busy/exc_ack/status_error=0.
- Condition codes (combinational, from registered flags):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 never (0).
- New flags: N=alu_result MSB; Z=(alu_result==0) over full DATA_WIDTH; C=alu_carry; V=alu_overflow.
- Flag write: when FSM=IDLE, set_cond_bit=1 and write_condition=1, NZCV updates on the next edge. I and mode are untouched. One-cycle latency to current_flags.
- Entry FSM states: IDLE, SAVE, SWITCH.
  - IDLE: on exc_req with valid exc_mode (1..NUM_MODES-1), latch exc_mode and go to SAVE.
  - IDLE, invalid exc_mode (0 or >=NUM_MODES): pulse status_error, stay IDLE, request ignored.
  - SAVE: SPSR[latched] <= CPSR, as it stands after any flag write accepted in the IDLE cycle.
  - SWITCH: mode <= latched, I <= 1, NZCV unchanged, exc_ack=1 for this cycle, then return to IDLE.
  - Total: request accepted at edge 0; busy high for 2 cycles; cpsr_out shows new mode after edge 2.
- While busy: set_cond_bit and exc_return are ignored; write_condition is still driven normally.
- Exception return (IDLE only):
  - mode!=0: CPSR <= SPSR[mode] (NZCV, I, mode) on the next edge.
  - mode==0: status_error pulse, no change.
  - Restored mode field out of range: CPSR still loaded, status_error pulses.
- Simultaneous events in IDLE:
  - exc_req + exc_return: entry wins, return dropped.
  - exc_return + flag write: return wins, flag write discarded.
  - exc_req + flag write: flag write committed first, then SAVE stores the updated flags.
- Re-entry into the current mode overwrites that mode's SPSR (no nesting protection).
- Reset mid-sequence: FSM returns to IDLE immediately, no exc_ack issued, any partial SPSR write discarded by reset.

Test Plan:
- Reset then idle: cpsr_out=0x00000081 (I=1, mode 1), spsr_out=0, busy=0. Then cond=EQ gives write_condition=0; cond=1110 gives 1; cond=1111 gives 0.
- alu_result=0, carry=1, overflow=0, set_cond_bit=1, cond=AL: next cycle current_flags=4'b0110. Then cond=HI gives 0, LS gives 1. Next alu_result=0x80000000, overflow=1, cond=EQ: flags update to 4'b1001. Then GE=1, LT=0.
- From mode 1 with flags 4'b1000, exc_req with exc_mode=2 plus same-cycle flag write of 4'b0100: busy=1 for 2 cycles, exc_ack on the 2nd. SPSR[2]=0x40000081; cpsr_out=0x40000082.
- In mode 2, exc_return pulse together with set_cond_bit (alu_result=0): next cycle cpsr_out=0x40000081, the flag write is discarded.
- exc_req with exc_mode=0: status_error pulses, cpsr_out unchanged, busy stays 0. Then exc_return in mode 0 (set up via a restored SPSR whose mode=0): status_error pulses, no change.
- Assert reset in the SAVE cycle: outputs return to reset values asynchronously, exc_ack never asserts, SPSR[target]=0.
